// File: rtl/aes_encipher_block_p.sv
// aes_encipher_block_p: AES-128/192/256 encipher datapath and FSM. SubBytes runs on
// NUM_SBOX words per cycle through an external combinational S-box bank.
module aes_encipher_block_p #(
    parameter int NUM_SBOX = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    next,
    input  logic                    abort,
    input  logic [1:0]              keylen,
    output logic [3:0]              round,
    input  logic [127:0]            round_key,
    output logic [32*NUM_SBOX-1:0]  sboxw,
    input  logic [32*NUM_SBOX-1:0]  new_sboxw,
    input  logic [127:0]            block,
    output logic [127:0]            new_block,
    output logic                    ready,
    output logic                    done
);
    localparam int SBOX_CYCLES = 4 / NUM_SBOX;

    if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
        $error("NUM_SBOX must be 1, 2 or 4");
    end

    // FIN is the extra cycle after the final round before done/ready assert.
    typedef enum logic [2:0] {IDLE, INIT, SBOX, MAIN, FIN} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic [1:0]   sword_ctr_q, sword_ctr_d;
    logic [1:0]   keylen_q, keylen_d;
    logic         ready_q, ready_d;
    logic         done_q, done_d;
    logic [3:0]   nr;
    logic         last_grp;
    logic [31:0]  w [4];
    logic [31:0]  sub [4];

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_word(input logic [31:0] x);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = x;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Row r of column c comes from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*((c + r) % 4) - 8*r -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        return {mix_word(s[127:96]), mix_word(s[95:64]), mix_word(s[63:32]), mix_word(s[31:0])};
    endfunction

    assign nr       = (keylen_q == 2'b01) ? 4'd14 : (keylen_q == 2'b10) ? 4'd12 : 4'd10;
    assign last_grp = (int'(sword_ctr_q) == SBOX_CYCLES - 1);

    always_comb begin
        for (int i = 0; i < 4; i++)
            w[i] = state_q[127 - 32*i -: 32];
    end

    always_comb begin
        sboxw = '0;
        sub   = w;
        for (int j = 0; j < NUM_SBOX; j++) begin
            if (fsm_q == SBOX)
                sboxw[32*j +: 32] = w[2'(int'(sword_ctr_q) * NUM_SBOX + j)];
            sub[2'(int'(sword_ctr_q) * NUM_SBOX + j)] = new_sboxw[32*j +: 32];
        end
    end

    always_comb begin
        fsm_d       = fsm_q;
        state_d     = state_q;
        round_ctr_d = round_ctr_q;
        sword_ctr_d = sword_ctr_q;
        keylen_d    = keylen_q;
        ready_d     = ready_q;
        done_d      = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (abort) begin
                    state_d = '0;
                end else if (next) begin
                    round_ctr_d = 4'd0;
                    keylen_d    = keylen;
                    ready_d     = 1'b0;
                    fsm_d       = INIT;
                end
            end
            INIT: begin
                state_d     = block ^ round_key;
                round_ctr_d = 4'd1;
                sword_ctr_d = 2'd0;
                fsm_d       = SBOX;
            end
            SBOX: begin
                state_d     = {sub[0], sub[1], sub[2], sub[3]};
                sword_ctr_d = last_grp ? 2'd0 : sword_ctr_q + 2'd1;
                fsm_d       = last_grp ? MAIN : SBOX;
            end
            MAIN: begin
                if (round_ctr_q < nr) begin
                    state_d     = mix_columns(shift_rows(state_q)) ^ round_key;
                    round_ctr_d = round_ctr_q + 4'd1;
                    fsm_d       = SBOX;
                end else begin
                    state_d = shift_rows(state_q) ^ round_key;
                    fsm_d   = FIN;
                end
            end
            FIN: begin
                ready_d = 1'b1;
                done_d  = 1'b1;
                fsm_d   = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
        if (abort && fsm_q != IDLE) begin
            state_d     = '0;
            fsm_d       = IDLE;
            ready_d     = 1'b1;
            done_d      = 1'b0;
            round_ctr_d = 4'd0;
            sword_ctr_d = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            round_ctr_q <= 4'd0;
            sword_ctr_q <= 2'd0;
            keylen_q    <= 2'b00;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            round_ctr_q <= round_ctr_d;
            sword_ctr_q <= sword_ctr_d;
            keylen_q    <= keylen_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign round     = round_ctr_q;
    assign new_block = state_q;
    assign ready     = ready_q;
    assign done      = done_q;
endmodule

// File: tb/tb_aes_encipher_block_p.sv
// tb_aes_encipher_block_p: three DUTs (NUM_SBOX 1/2/4) on shared stimulus, checked each
// cycle against a byte-level AES model plus cycle-count timing expectations.
module tb_aes_encipher_block_p;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 0, reset_n = 0, next = 0, abort = 0;
    logic [1:0]   keylen = 2'b00;
    logic [127:0] block = '0;
    logic [127:0] rk [16];
    logic [7:0]   sbox [256];
    logic [2:0]   rdy_a, dn_a;
    logic [3:0]   rnd_a [3];
    logic [127:0] nb_a [3], sbw_a [3];
    int           vectors = 0, errors = 0;

    bit           m_busy [3], m_done [3];
    int           m_k [3], m_nr [3];
    logic [3:0]   m_rnd [3];
    logic [127:0] m_nb [3], m_ciph [3], m_init [3];

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    function automatic int nr_of(input logic [1:0] kl);
        return kl == 2'b01 ? 14 : kl == 2'b10 ? 12 : 10;
    endfunction

    function automatic int nk_of(input logic [1:0] kl);
        return kl == 2'b01 ? 8 : kl == 2'b10 ? 6 : 4;
    endfunction

    // FIPS-197 cipher on a 16-byte array, s[4c+r] = row r of column c.
    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input int nr);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++) s[4*c+w] = t[4*((c+w)%4)+w];
            if (r < nr)
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 2) ^ gmul(a1, 3) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 2) ^ gmul(a2, 3) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 2) ^ gmul(a3, 3);
                    s[4*c+3] = gmul(a0, 3) ^ a1 ^ a2 ^ gmul(a3, 2);
                end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic set_key(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 60; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk == 8 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 15; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        rk[15] = '0;
    endtask

    task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, inst, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int N = 1 << g;
        logic [32*N-1:0] sbw, nsbw;
        logic [3:0]      rnd;
        logic [127:0]    nb;
        logic            rdy, dn;
        always_comb begin
            nsbw = '0;
            for (int j = 0; j < N; j++) nsbw[32*j +: 32] = subw(sbw[32*j +: 32]);
        end
        aes_encipher_block_p #(.NUM_SBOX(N)) dut (
            .clk(clk), .reset_n(reset_n), .next(next), .abort(abort), .keylen(keylen),
            .round(rnd), .round_key(rk[rnd]), .sboxw(sbw), .new_sboxw(nsbw),
            .block(block), .new_block(nb), .ready(rdy), .done(dn));
        assign rdy_a[g] = rdy;
        assign dn_a[g]  = dn;
        assign rnd_a[g] = rnd;
        assign nb_a[g]  = nb;
        assign sbw_a[g] = 128'(sbw);
    end

    // Model: k counts cycles since accept (k=0 is the INIT cycle); done arrives at k = Nr*(SC+1)+2.
    always @(negedge clk) begin
        int sc, per, last, k;
        logic e_rdy, e_dn, sbc;
        logic [3:0] e_rnd;
        for (int i = 0; i < 3; i++) begin
            sc = 4 >> i;
            per = sc + 1;
            if (!reset_n) begin
                m_busy[i] = 0; m_done[i] = 0; m_rnd[i] = 0; m_nb[i] = '0; m_k[i] = 0;
            end
            k = m_k[i];
            last = m_nr[i] * per;
            if (m_busy[i]) begin
                e_rdy = 0; e_dn = 0;
                e_rnd = (k == 0) ? 4'd0 : (k > last) ? 4'(m_nr[i]) : 4'((k - 1) / per + 1);
                sbc = k >= 1 && k <= last && ((k - 1) % per) < sc;
            end else begin
                e_rdy = 1; e_dn = m_done[i]; e_rnd = m_rnd[i]; sbc = 0;
            end
            chk("ready", i, 128'(rdy_a[i]), 128'(e_rdy));
            chk("done", i, 128'(dn_a[i]), 128'(e_dn));
            chk("round", i, 128'(rnd_a[i]), 128'(e_rnd));
            if (!sbc) chk("sboxw_idle", i, sbw_a[i], '0);
            if (m_busy[i] && k == 1) chk("init_ark", i, nb_a[i], m_init[i]);
            else if (m_busy[i] && k == last + 1) chk("cipher", i, nb_a[i], m_ciph[i]);
            else if (!m_busy[i] || k == 0) chk("new_block", i, nb_a[i], m_nb[i]);
            if (reset_n) begin
                if (m_busy[i]) begin
                    if (abort) begin
                        m_busy[i] = 0; m_nb[i] = '0; m_rnd[i] = 0; m_done[i] = 0;
                    end else begin
                        m_k[i]++;
                        if (m_k[i] == last + 2) begin
                            m_busy[i] = 0; m_done[i] = 1; m_nb[i] = m_ciph[i]; m_rnd[i] = 4'(m_nr[i]);
                        end
                    end
                end else begin
                    m_done[i] = 0;
                    if (abort) m_nb[i] = '0;
                    else if (next) begin
                        m_busy[i] = 1; m_k[i] = 0; m_nr[i] = nr_of(keylen);
                        m_ciph[i] = aes_ref(block, m_nr[i]);
                        m_init[i] = block ^ rk[0];
                    end
                end
            end
        end
    end

    task automatic start(input logic [255:0] key, input int nk, input logic [1:0] kl, input logic [127:0] pt);
        set_key(key, nk);
        block = pt;
        keylen = kl;
        next = 1;
        @(posedge clk); #2;
        next = 0;
    endtask

    task automatic wait_idle();
        next = 0;
        abort = 0;
        for (int c = 0; c < 400; c++) begin
            if (&rdy_a) return;
            @(posedge clk); #2;
        end
        vectors++;
        errors++;
        $display("FAIL wait_idle timeout: ready=%b expected 111", rdy_a);
    endtask

    initial begin
        logic [7:0] inv;
        logic [255:0] key;
        logic [1:0] kl;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                      ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        for (int r = 0; r < 16; r++) rk[r] = '0;
        chk("sbox_00", 0, 128'(sbox[8'h00]), 128'h63);
        chk("sbox_53", 0, 128'(sbox[8'h53]), 128'hed);
        set_key(K128, 4);
        chk("ref_aes128", 0, aes_ref(PT, 10), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        set_key(K192, 6);
        chk("ref_aes192", 0, aes_ref(PT, 12), 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
        set_key(K256, 8);
        chk("ref_aes256", 0, aes_ref(PT, 14), 128'h8ea2b7ca516745bfeafc49904b496089);
        repeat (3) @(posedge clk);
        #2 reset_n = 1;
        @(posedge clk); #2;
        start(K128, 4, 2'b00, PT); wait_idle();
        start(K192, 6, 2'b10, PT); wait_idle();
        start(K256, 8, 2'b01, PT); wait_idle();
        start(K128, 4, 2'b11, PT); wait_idle();
        // abort in IDLE wins over next
        next = 1; abort = 1;
        @(posedge clk); #2;
        next = 0; abort = 0;
        @(posedge clk); #2;
        // abort in 3rd SBOX cycle of round 5 for the NUM_SBOX=1 instance
        start(K128, 4, 2'b00, PT);
        repeat (23) @(posedge clk);
        #2 abort = 1;
        @(posedge clk); #2;
        abort = 0;
        wait_idle();
        start(K128, 4, 2'b00, PT); wait_idle();
        // next held high, keylen toggling every cycle
        set_key(K128, 4);
        block = PT;
        next = 1;
        for (int c = 0; c < 150; c++) begin
            keylen = 2'($urandom);
            @(posedge clk); #2;
        end
        wait_idle();
        // asynchronous reset mid-operation
        start(K256, 8, 2'b01, PT);
        repeat (20) @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("async_rst_ready", 0, 128'(rdy_a[0]), 128'h1);
        chk("async_rst_round", 0, 128'(rnd_a[0]), 128'h0);
        chk("async_rst_block", 0, nb_a[0], '0);
        @(posedge clk); #2;
        reset_n = 1;
        @(posedge clk); #2;
        start(K128, 4, 2'b00, PT); wait_idle();
        for (int op = 0; op < 12; op++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            kl = 2'($urandom);
            start(key, nk_of(kl), kl, {$urandom, $urandom, $urandom, $urandom});
            for (int c = 0; c < 300 && !(&rdy_a); c++) begin
                next = ($urandom % 6 == 0);
                abort = ($urandom % 90 == 0);
                keylen = 2'($urandom);
                @(posedge clk); #2;
            end
            wait_idle();
        end
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/aes_encipher_block_p.md
Name: aes_encipher_block_p

Overview:
Parametrised next-generation AES encipher datapath/FSM for 128-, 192- and 256-bit keys. It performs the initial AddRoundKey, the main rounds and the final round on one 128-bit block. SubBytes runs on NUM_SBOX 32-bit words per cycle through external shared S-boxes. It sits between the core control and the key memory and S-box bank, and adds latched key length, a done strobe, and a synchronous abort that wipes state.

Parameters:
NUM_SBOX, 1, 32-bit S-box words substituted per cycle; legal values 1, 2, 4; any other value is an elaboration error.

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
next  in  1  start request; accepted only when ready=1
abort  in  1  synchronous abort; wins over all other activity
keylen  in  2  00=AES-128 (10 rounds), 01=AES-256 (14), 10=AES-192 (12), 11=reserved (treated as 00); sampled when next is accepted
round  out  4  round-key index; round_key must be valid combinationally for this index in the same cycle
round_key  in  128  round key for index round
sboxw  out  32*NUM_SBOX  words to substitute; word k at bits [32k+31:32k]
new_sboxw  in  32*NUM_SBOX  combinational S-box results, same packing
block  in  128  plaintext; sampled in the INIT cycle
new_block  out  128  state register {w0,w1,w2,w3}; w0 = bits 127:96
ready  out  1  idle, can accept next
done  out  1  one-cycle pulse when the ciphertext is valid on new_block

Behaviour:
- Reset values: state registers 0, round 0, sboxw 0, ready 1, done 0, FSM IDLE, keylen_reg 00, sword_ctr 0.
- Number of rounds Nr is taken from keylen_reg, latched at accept; changes to keylen during an operation have no effect.
- SBOX_CYCLES = 4/NUM_SBOX.
- IDLE:
  - next=1 causes round_ctr<=0, keylen_reg<=keylen, ready<=0, and a move to INIT.
  - next while ready=0 is ignored, never queued.
- INIT (1 cycle):
  - state <= block ^ round_key, where round=0.
  - round_ctr<=1, sword_ctr<=0, go to SBOX.
- SBOX (SBOX_CYCLES cycles):
  - Each cycle, words sword_ctr*NUM_SBOX .. +NUM_SBOX-1 drive sboxw, and the same words are written with new_sboxw.
  - sword_ctr increments each cycle. On the last group, sword_ctr returns to 0 and the FSM moves to MAIN.
  - sboxw is 0 in every other state.
- MAIN (1 cycle, round=round_ctr):
  - If round_ctr<Nr: state <= MixColumns(ShiftRows(state)) ^ round_key; round_ctr++; go to SBOX.
  - Else (final round): state <= ShiftRows(state) ^ round_key; ready<=1 and done<=1 in the next cycle; go to IDLE.
  - round_ctr is held at Nr in IDLE until the next accept.
- Arithmetic:
  - GF(2^8) xtime = {b[6:0],0} ^ (0x1b if b[7]).
  - MixColumns and ShiftRows are per FIPS-197, with column-major words (w0 = column 0, byte 0 = row 0).
- Latency: next accepted at edge T puts the result in new_block with done=1 and ready=1 at T + 1 + 1 + Nr*(SBOX_CYCLES+1).
  - NUM_SBOX=1, AES-128: result at T+52.
  - NUM_SBOX=4, AES-256: result at T+30.
- done:
  - High for exactly one cycle.
  - new_block holds the ciphertext until the next INIT or an abort.
  - next may be asserted in the same cycle done=1 (ready=1); back-to-back starts are legal.
- Abort:
  - In any non-IDLE state, abort=1 causes next cycle: state registers <= 0, FSM IDLE, ready=1, done=0, round_ctr=0, sword_ctr=0.
  - In IDLE, abort clears the state registers, and next in the same cycle is ignored.
- Reset asserted mid-operation: immediate return to reset values; no done pulse.
- keylen=11 behaves exactly as 00.

Test Plan:
- AES-128, NUM_SBOX=1, key 000102..0f (bench supplies the expanded schedule indexed by round), block 00112233445566778899aabbccddeeff -> new_block 69c4e0d86a7b0430d8cdb78070b4c55a, done exactly 52 cycles after the next edge, ready low throughout.
- AES-192, key 000102..17, same plaintext, NUM_SBOX=2 -> dda97ca4864cdfe06eaf70a0ec0d7191; AES-256, key 000102..1f, NUM_SBOX=4 -> 8ea2b7ca516745bfeafc49904b496089, done at T+30.
- Round index trace: for AES-128 with NUM_SBOX=1, round sequence 0,1(x5),2(x5),...,10 held; no index above Nr ever appears; sboxw=0 outside SBOX.
- Abort issued in the 3rd SBOX cycle of round 5 -> next cycle new_block=0, ready=1, no done; a following start with the FIPS-197 vector still yields 69c4e0d8... .
- Back-to-back: next held high continuously -> a second operation starts in the done cycle; next asserted while busy is ignored (exactly one done per accepted start); keylen toggled mid-operation does not change the result.
- Reset pulsed mid-operation -> all outputs at reset values asynchronously; a subsequent operation is correct.
